// File: rtl/pool_pack_pkg.sv
// Shared widths, FSM/type encodings and the data FIFO entry layout for the
// POOL output packer.
package pool_pack_pkg;

  localparam int DATA_W          = 96;
  localparam int FLG_W           = 24;
  localparam int ADDR_W          = 12;
  localparam int CNT_W           = 16;
  localparam int DFIFO_DEPTH_DEF = 8;
  localparam int FFIFO_DEPTH_DEF = 4;
  localparam int BURST_DEF       = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic {TYPE_DAT = 1'b0, TYPE_FLG = 1'b1} type_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dat_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; writes and reads take effect
// at the rising edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_wr, do_rd;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_wr) - LW'(do_rd);
    end
  end

  // NOTE: storage is not reset; emptying the pointers makes stale entries
  // unreachable, and leaving the array out of reset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pool_out_packer.sv
// Buffers POOL data and flag words in separate FIFOs, merges them onto one
// addressed output port with a burst arbiter, and signals frame completion.
import pool_pack_pkg::*;

module pool_out_packer #(
  parameter int DFIFO_DEPTH = DFIFO_DEPTH_DEF,
  parameter int FFIFO_DEPTH = FFIFO_DEPTH_DEF,
  parameter int BURST       = BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CCUPACK_start,
  input  logic [CNT_W-1:0]  CCUPACK_DatNum,
  input  logic [CNT_W-1:0]  CCUPACK_FlgNum,
  output logic              PACKCCU_fnh,
  output logic              BF_rdy,
  input  logic              BF_val,
  input  logic [ADDR_W-1:0] BF_addr,
  input  logic [DATA_W-1:0] BF_data,
  output logic              BF_flg_rdy,
  input  logic              BF_flg_val,
  input  logic [FLG_W-1:0]  BF_flg_data,
  output logic              PACKOFF_val,
  input  logic              OFFPACK_rdy,
  output logic              PACKOFF_type,
  output logic [ADDR_W-1:0] PACKOFF_addr,
  output logic [DATA_W-1:0] PACKOFF_data
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_L = BW'(BURST);

  state_e            state_q;
  logic [CNT_W-1:0]  dat_num_q, flg_num_q, acc_dat_q, acc_flg_q, sent_dat_q, sent_flg_q;
  logic [ADDR_W-1:0] flg_idx_q;
  type_e             grant_q, grant_d, out_type_q;
  logic [BW-1:0]     burst_q, burst_d;
  logic              out_val_q, fnh_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  dat_entry_t        d_wr, d_head;
  logic [FLG_W-1:0]  f_head;
  logic              d_full, d_empty, f_full, f_empty;
  logic              dat_acc, flg_acc, out_hs;
  logic              load_ok, cur_ne, oth_ne, pick_dat, pick_flg;

  assign BF_rdy     = (state_q == RUN) && !d_full && (acc_dat_q < dat_num_q);
  assign BF_flg_rdy = (state_q == RUN) && !f_full && (acc_flg_q < flg_num_q);
  assign dat_acc    = BF_val && BF_rdy;
  assign flg_acc    = BF_flg_val && BF_flg_rdy;
  assign out_hs     = out_val_q && OFFPACK_rdy;
  assign d_wr       = {BF_addr, BF_data};

  assign PACKCCU_fnh  = fnh_q;
  assign PACKOFF_val  = out_val_q;
  assign PACKOFF_type = out_type_q;
  assign PACKOFF_addr = out_addr_q;
  assign PACKOFF_data = out_data_q;

  sync_fifo #(.WIDTH($bits(dat_entry_t)), .DEPTH(DFIFO_DEPTH)) u_dfifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(dat_acc), .wr_data_i(d_wr),
    .rd_en_i(pick_dat), .rd_data_o(d_head),
    .full_o(d_full), .empty_o(d_empty)
  );

  sync_fifo #(.WIDTH(FLG_W), .DEPTH(FFIFO_DEPTH)) u_ffifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(flg_acc), .wr_data_i(BF_flg_data),
    .rd_en_i(pick_flg), .rd_data_o(f_head),
    .full_o(f_full), .empty_o(f_empty)
  );

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_d  = grant_q;
    burst_d  = burst_q;
    pick_dat = 1'b0;
    pick_flg = 1'b0;
    load_ok  = (state_q == RUN) && (!out_val_q || OFFPACK_rdy);
    cur_ne   = (grant_q == TYPE_DAT) ? !d_empty : !f_empty;
    oth_ne   = (grant_q == TYPE_DAT) ? !f_empty : !d_empty;
    if (load_ok) begin
      if (cur_ne && (burst_q < BURST_L)) begin
        burst_d = burst_q + BW'(1);
      end else if (oth_ne) begin
        grant_d = (grant_q == TYPE_DAT) ? TYPE_FLG : TYPE_DAT;
        burst_d = BW'(1);
      end else if (cur_ne) begin
        burst_d = BW'(1);  // burst exhausted but no competitor: start a fresh one
      end
      if (cur_ne || oth_ne) begin
        pick_dat = (grant_d == TYPE_DAT);
        pick_flg = (grant_d == TYPE_FLG);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dat_num_q  <= '0;
      flg_num_q  <= '0;
      acc_dat_q  <= '0;
      acc_flg_q  <= '0;
      sent_dat_q <= '0;
      sent_flg_q <= '0;
      flg_idx_q  <= '0;
      grant_q    <= TYPE_DAT;
      burst_q    <= '0;
      out_val_q  <= 1'b0;
      out_type_q <= TYPE_DAT;
      out_addr_q <= '0;
      out_data_q <= '0;
      fnh_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fnh_q <= 1'b0;
          if (CCUPACK_start) begin
            state_q    <= RUN;
            dat_num_q  <= CCUPACK_DatNum;
            flg_num_q  <= CCUPACK_FlgNum;
            acc_dat_q  <= '0;
            acc_flg_q  <= '0;
            sent_dat_q <= '0;
            sent_flg_q <= '0;
            flg_idx_q  <= '0;
            grant_q    <= TYPE_DAT;
            burst_q    <= '0;
          end
        end
        RUN: begin
          if (dat_acc) acc_dat_q <= acc_dat_q + CNT_W'(1);
          if (flg_acc) acc_flg_q <= acc_flg_q + CNT_W'(1);
          if (out_hs && out_type_q == TYPE_DAT) sent_dat_q <= sent_dat_q + CNT_W'(1);
          if (out_hs && out_type_q == TYPE_FLG) sent_flg_q <= sent_flg_q + CNT_W'(1);
          grant_q <= grant_d;
          burst_q <= burst_d;
          if (pick_dat) begin
            out_val_q  <= 1'b1;
            out_type_q <= TYPE_DAT;
            out_addr_q <= d_head.addr;
            out_data_q <= d_head.data;
          end else if (pick_flg) begin
            out_val_q  <= 1'b1;
            out_type_q <= TYPE_FLG;
            out_addr_q <= flg_idx_q;
            out_data_q <= {{(DATA_W-FLG_W){1'b0}}, f_head};
            flg_idx_q  <= flg_idx_q + ADDR_W'(1);
          end else if (out_hs) begin
            out_val_q <= 1'b0;
          end
          if (sent_dat_q == dat_num_q && sent_flg_q == flg_num_q && !out_val_q) begin
            state_q <= DONE;
            fnh_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          fnh_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_out_packer.sv
// Directed-random bench for pool_out_packer: source queues feed both streams,
// a per-cycle monitor logs handshakes, and results are compared to a model.
module tb_pool_out_packer;
  import pool_pack_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              CCUPACK_start = 1'b0;
  logic [CNT_W-1:0]  CCUPACK_DatNum = '0;
  logic [CNT_W-1:0]  CCUPACK_FlgNum = '0;
  logic              PACKCCU_fnh;
  logic              BF_rdy;
  logic              BF_val = 1'b0;
  logic [ADDR_W-1:0] BF_addr = '0;
  logic [DATA_W-1:0] BF_data = '0;
  logic              BF_flg_rdy;
  logic              BF_flg_val = 1'b0;
  logic [FLG_W-1:0]  BF_flg_data = '0;
  logic              PACKOFF_val;
  logic              OFFPACK_rdy = 1'b0;
  logic              PACKOFF_type;
  logic [ADDR_W-1:0] PACKOFF_addr;
  logic [DATA_W-1:0] PACKOFF_data;

  always #5 clk = ~clk;

  pool_out_packer dut (
    .clk(clk), .rst_n(rst_n),
    .CCUPACK_start(CCUPACK_start), .CCUPACK_DatNum(CCUPACK_DatNum),
    .CCUPACK_FlgNum(CCUPACK_FlgNum), .PACKCCU_fnh(PACKCCU_fnh),
    .BF_rdy(BF_rdy), .BF_val(BF_val), .BF_addr(BF_addr), .BF_data(BF_data),
    .BF_flg_rdy(BF_flg_rdy), .BF_flg_val(BF_flg_val), .BF_flg_data(BF_flg_data),
    .PACKOFF_val(PACKOFF_val), .OFFPACK_rdy(OFFPACK_rdy),
    .PACKOFF_type(PACKOFF_type), .PACKOFF_addr(PACKOFF_addr), .PACKOFF_data(PACKOFF_data)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dword_t;

  typedef struct {
    logic              typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } oword_t;

  dword_t           dsrc[$], exp_d[$];
  logic [FLG_W-1:0] fsrc[$], exp_f[$];
  oword_t           olog[$];
  int               dacc_cyc[$], fnh_cyc[$];
  bit               exp_types[$];
  int               facc_n, cyc, start_c, total, bad;
  bit               d_en, f_en, d_hs, f_hs, any_rdy;
  logic             s_val, s_type, s_fnh, s_brdy, s_frdy;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    BF_val = d_en && (dsrc.size() > 0);
    if (dsrc.size() > 0) begin
      BF_addr = dsrc[0].addr;
      BF_data = dsrc[0].data;
    end
    BF_flg_val = f_en && (fsrc.size() > 0);
    if (fsrc.size() > 0) BF_flg_data = fsrc[0];
  endtask

  // One clock cycle: observe mid-cycle, then advance sources after the edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_val  = PACKOFF_val;
    s_type = PACKOFF_type;
    s_addr = PACKOFF_addr;
    s_data = PACKOFF_data;
    s_fnh  = PACKCCU_fnh;
    s_brdy = BF_rdy;
    s_frdy = BF_flg_rdy;
    d_hs   = BF_val && BF_rdy;
    f_hs   = BF_flg_val && BF_flg_rdy;
    if (s_brdy || s_frdy) any_rdy = 1'b1;
    if (PACKOFF_val && OFFPACK_rdy) olog.push_back('{PACKOFF_type, PACKOFF_addr, PACKOFF_data, cyc});
    if (d_hs) dacc_cyc.push_back(cyc);
    if (f_hs) facc_n++;
    if (PACKCCU_fnh) fnh_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    if (d_hs && dsrc.size() > 0) void'(dsrc.pop_front());
    if (f_hs && fsrc.size() > 0) void'(fsrc.pop_front());
    drive();
  endtask

  task automatic clear_logs();
    olog.delete();
    dacc_cyc.delete();
    fnh_cyc.delete();
    facc_n  = 0;
    any_rdy = 1'b0;
  endtask

  task automatic start_frame(input int dn, input int fn);
    clear_logs();
    CCUPACK_DatNum = CNT_W'(dn);
    CCUPACK_FlgNum = CNT_W'(fn);
    CCUPACK_start  = 1'b1;
    tick();
    start_c       = cyc;
    CCUPACK_start = 1'b0;
  endtask

  task automatic gen_data(input int n, input bit seq, input int base);
    dword_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = seq ? ADDR_W'(base + i) : ADDR_W'($urandom);
      w.data = {$urandom, $urandom, $urandom};
      dsrc.push_back(w);
      exp_d.push_back(w);
    end
  endtask

  task automatic gen_flg(input int n, input int extra);
    logic [FLG_W-1:0] f;
    for (int i = 0; i < n + extra; i++) begin
      f = FLG_W'($urandom);
      fsrc.push_back(f);
      if (i < n) exp_f.push_back(f);
    end
  endtask

  task automatic wait_fnh(input string tag, input int budget);
    int n = 0;
    while (fnh_cyc.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_fnh_seen"}, fnh_cyc.size() != 0, 1'b1);
    repeat (3) tick();
    check({tag, "_fnh_width"}, fnh_cyc.size(), 1);
  endtask

  // Each stream must come out in acceptance order; flags carry 0,1,2,...
  task automatic check_stream(input string tag);
    int di = 0;
    int fi = 0;
    foreach (olog[i]) begin
      if (olog[i].typ == 1'b0) begin
        if (di < exp_d.size()) begin
          check({tag, "_dat_addr"}, olog[i].addr, exp_d[di].addr);
          check({tag, "_dat_data"}, olog[i].data, exp_d[di].data);
        end
        di++;
      end else begin
        if (fi < exp_f.size()) begin
          check({tag, "_flg_addr"}, olog[i].addr, ADDR_W'(fi));
          check({tag, "_flg_data"}, olog[i].data, DATA_W'(exp_f[fi]));
        end
        fi++;
      end
    end
    check({tag, "_n_dat"}, di, exp_d.size());
    check({tag, "_n_flg"}, fi, exp_f.size());
    exp_d.delete();
    exp_f.delete();
  endtask

  function automatic bit contiguous();
    foreach (olog[i]) if (olog[i].cyc != olog[0].cyc + i) return 1'b0;
    return 1'b1;
  endfunction

  // Expected type sequence when neither stream ever runs dry.
  task automatic build_pattern(input int dn, input int fn);
    int rem[2];
    int cur = 0;
    int n;
    rem[0] = dn;
    rem[1] = fn;
    exp_types.delete();
    while (rem[0] + rem[1] > 0) begin
      if (rem[cur] == 0) cur = 1 - cur;
      n = (rem[cur] < BURST_DEF) ? rem[cur] : BURST_DEF;
      repeat (n) exp_types.push_back(cur[0]);
      rem[cur] -= n;
      if (rem[1 - cur] > 0) cur = 1 - cur;
    end
  endtask

  initial begin
    bit held_v, stable;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    int n;
    total = 0;
    bad   = 0;
    cyc   = 0;
    d_en  = 1'b0;
    f_en  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_val", s_val, 1'b0);
    check("rst_brdy", s_brdy, 1'b0);
    check("rst_frdy", s_frdy, 1'b0);
    check("rst_fnh", s_fnh, 1'b0);
    rst_n = 1'b1;
    tick();

    // Zero-count frame
    start_frame(0, 0);
    repeat (5) tick();
    check("zero_fnh_cnt", fnh_cyc.size(), 1);
    if (fnh_cyc.size() > 0) check("zero_fnh_at", fnh_cyc[0] - start_c, 2);
    check("zero_no_rdy", any_rdy, 1'b0);

    // Data only, sequential addresses 5,6,7
    OFFPACK_rdy = 1'b1;
    gen_data(3, 1'b1, 5);
    d_en = 1'b1;
    drive();
    start_frame(3, 0);
    wait_fnh("donly", 50);
    if (olog.size() > 0 && dacc_cyc.size() > 0) check("donly_latency", olog[0].cyc - dacc_cyc[0], 2);
    check("donly_b2b", contiguous(), 1'b1);
    if (olog.size() > 0 && fnh_cyc.size() > 0) check("donly_fnh_at", fnh_cyc[0] - olog[olog.size()-1].cyc, 2);
    check_stream("donly");

    // Interleave with both streams pre-filled
    OFFPACK_rdy = 1'b0;
    gen_data(10, 1'b0, 0);
    gen_flg(6, 0);
    f_en = 1'b1;
    drive();
    start_frame(10, 6);
    repeat (16) tick();
    check("ilv_prefill_dat", dacc_cyc.size(), 9);
    check("ilv_prefill_flg", facc_n, 4);
    OFFPACK_rdy = 1'b1;
    wait_fnh("ilv", 100);
    build_pattern(10, 6);
    check("ilv_len", olog.size(), exp_types.size());
    foreach (olog[i]) if (i < exp_types.size()) check("ilv_type", olog[i].typ, exp_types[i]);
    check("ilv_b2b", contiguous(), 1'b1);
    check_stream("ilv");
    f_en = 1'b0;

    // Backpressure: sink stalled for 20 cycles
    OFFPACK_rdy = 1'b0;
    gen_data(12, 1'b0, 0);
    drive();
    start_frame(12, 0);
    held_v = 1'b0;
    stable = 1'b1;
    h_addr = '0;
    h_data = '0;
    repeat (20) begin
      tick();
      if (s_val) begin
        if (!held_v) begin
          held_v = 1'b1;
          h_addr = s_addr;
          h_data = s_data;
        end else if (s_addr !== h_addr || s_data !== h_data || s_type !== 1'b0) begin
          stable = 1'b0;
        end
      end
    end
    check("bp_accepted", dacc_cyc.size(), 9);
    check("bp_brdy_low", s_brdy, 1'b0);
    check("bp_val_held", held_v, 1'b1);
    check("bp_stable", stable, 1'b1);
    check("bp_head_addr", h_addr, exp_d[0].addr);
    OFFPACK_rdy = 1'b1;
    wait_fnh("bp", 100);
    check("bp_b2b", contiguous(), 1'b1);
    check_stream("bp");
    d_en = 1'b0;

    // Over-supply: flag valid held for 5 cycles, only 2 expected
    gen_flg(2, 3);
    f_en = 1'b1;
    drive();
    start_frame(0, 2);
    repeat (4) tick();
    check("over_accepted", facc_n, 2);
    check("over_frdy_low", s_frdy, 1'b0);
    f_en = 1'b0;
    fsrc.delete();
    wait_fnh("over", 50);
    check_stream("over");

    // Reset in the middle of a 6-word frame
    OFFPACK_rdy = 1'b0;
    gen_data(6, 1'b0, 0);
    d_en = 1'b1;
    drive();
    start_frame(6, 0);
    n = 0;
    while (dacc_cyc.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    check("mrst_two_accepted", dacc_cyc.size(), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    d_en  = 1'b0;
    dsrc.delete();
    exp_d.delete();
    clear_logs();
    tick();
    check("mrst_val", s_val, 1'b0);
    check("mrst_brdy", s_brdy, 1'b0);
    check("mrst_fnh", s_fnh, 1'b0);
    repeat (5) tick();
    check("mrst_no_fnh", fnh_cyc.size(), 0);
    OFFPACK_rdy = 1'b1;
    gen_data(2, 1'b0, 0);
    gen_flg(1, 0);
    d_en = 1'b1;
    f_en = 1'b1;
    drive();
    start_frame(2, 1);
    wait_fnh("post", 50);
    check_stream("post");
    d_en = 1'b0;
    f_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
